arbiter_rr4_8b: RTL and testbench

Round-robin arbiter that shares the 8-bit 4:1 multiplexer `mux4t1_8b` among four requesters. It grants one requester at a time, drives the mux select from the registered grant, and forces rotation after a bounded burst so no requester can starve the others. It sits between four 8-bit producers and a single shared 8-bit consumer path.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/mux4t1_8b.sv | 23 ++
 rtl/arbiter_rr4_8b.sv | 94 +++++++++
 tb/tb_arbiter_rr4_8b.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: widths, FSM encoding
// and the wrap-around search used to pick the next owner.
package arb_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit of req at or after start, wrapping 3->0; returns start if none.
  function automatic logic [SEL_W-1:0] next_idx(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic             found;
    next_idx = start;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + SEL_W'(i);
      if (!found && req[idx]) begin
        next_idx = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4t1_8b.sv
// 8-bit 4:1 multiplexer; the shared data path the arbiter steers.
module mux4t1_8b
  import arb_pkg::*;
(
  output logic [DATA_W-1:0] F,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  input  logic [SEL_W-1:0]  Sel
);

  // NOTE: a fully covered case (or a default) keeps this purely combinational, no latch.
  always_comb begin
    case (Sel)
      2'd0:    F = A;
      2'd1:    F = B;
      2'd2:    F = C;
      default: F = D;
    endcase
  end

endmodule

// File: rtl/arbiter_rr4_8b.sv
// Round-robin arbiter over four requesters with a bounded burst length,
// driving the select of the shared 8-bit 4:1 mux from its registered grant.
module arbiter_rr4_8b
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  Req,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  output logic [N_REQ-1:0]  Gnt,
  output logic [SEL_W-1:0]  Sel,
  output logic              Valid,
  output logic [DATA_W-1:0] F
);

  state_e            state_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  logic              owner_req;
  logic              others_pend;
  logic              burst_done;
  logic [SEL_W-1:0]  pick;

  // In IDLE gnt_q is zero, so one search serves both first grant and hand-over.
  assign owner_req   = |(Req & gnt_q);
  assign others_pend = |(Req & ~gnt_q);
  assign burst_done  = (cnt_q == CNT_W'(MAX_BURST));
  assign pick        = next_idx(Req & ~gnt_q, ptr_q);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (others_pend) begin
            state_q <= GRANT;
            gnt_q   <= N_REQ'(1) << pick;
            sel_q   <= pick;
            ptr_q   <= pick + SEL_W'(1);
            cnt_q   <= CNT_W'(1);
            valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (others_pend && (!owner_req || burst_done)) begin
            gnt_q <= N_REQ'(1) << pick;
            sel_q <= pick;
            ptr_q <= pick + SEL_W'(1);
            cnt_q <= CNT_W'(1);
          end else if (!owner_req) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end else if (burst_done) begin
            cnt_q <= CNT_W'(1);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Gnt   = gnt_q;
  assign Sel   = sel_q;
  assign Valid = valid_q;

  mux4t1_8b u_mux (
    .F  (F),
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .Sel(sel_q)
  );

endmodule

// File: tb/tb_arbiter_rr4_8b.sv
// Self-checking bench for arbiter_rr4_8b: directed scenarios plus random
// traffic compared against an owner/pointer/burst reference model.
module tb_arbiter_rr4_8b;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Req;
  logic [7:0] A, B, C, D;
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Valid;
  logic [7:0] F;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_owner;   // -1 when idle
  int m_ptr;
  int m_cnt;
  int m_sel;

  arbiter_rr4_8b #(.MAX_BURST(MAXB)) dut (
    .clk  (clk),
    .rst  (rst),
    .Req  (Req),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .Gnt  (Gnt),
    .Sel  (Sel),
    .Valid(Valid),
    .F    (F)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] mask, input int start);
    for (int i = 0; i < 4; i++) begin
      if (mask[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] data_of(input int idx);
    case (idx)
      0:       return A;
      1:       return B;
      2:       return C;
      default: return D;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] req, input logic r);
    logic [3:0] others;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0) begin
        m_owner = first_from(req, m_ptr);
        m_cnt   = 1;
      end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (others != 4'b0 && (!req[m_owner] || m_cnt == MAXB)) begin
        m_owner = first_from(others, (m_owner + 1) % 4);
        m_cnt   = 1;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else begin
        m_cnt = (m_cnt == MAXB) ? 1 : m_cnt + 1;
      end
    end
    if (m_owner >= 0) begin
      m_sel = m_owner;
      m_ptr = (m_owner + 1) % 4;
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic tick(input logic [3:0] req, input logic r);
    logic [3:0] exp_gnt;
    @(negedge clk);
    Req = req;
    rst = r;
    @(posedge clk);
    model_step(req, r);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0 : (4'b1 << m_owner);
    check("gnt", 32'(Gnt), 32'(exp_gnt));
    check("sel", 32'(Sel), 32'(m_sel));
    check("valid", 32'(Valid), 32'(m_owner >= 0));
    check("f", 32'(F), 32'(data_of(m_sel)));
  endtask

  initial begin
    Req = 4'b0; rst = 1'b1;
    A = 8'h01; B = 8'h02; C = 8'h04; D = 8'h08;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;

    // Reset and idle
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    for (int j = 0; j < 5; j++) begin
      tick(4'b0000, 1'b0);
      check("idle_gnt", 32'(Gnt), 32'h0);
      check("idle_valid", 32'(Valid), 32'h0);
    end

    // All four requesting: 4-cycle bursts in order 0,1,2,3,0 without gaps
    for (int j = 0; j < 20; j++) begin
      logic [3:0] eg;
      tick(4'b1111, 1'b0);
      eg = 4'b0001 << ((j / 4) % 4);
      check("rr_gnt", 32'(Gnt), 32'(eg));
      check("rr_f", 32'(F), 32'({4'b0, eg}));
    end

    // Lone requester 1 keeps the grant past MAX_BURST
    for (int j = 0; j < 10; j++) begin
      tick(4'b0010, 1'b0);
      check("solo_gnt", 32'(Gnt), 32'h2);
      check("solo_f", 32'(F), 32'h02);
    end

    // Owner 2 drops while requester 0 waits: direct hand-over
    tick(4'b0100, 1'b0);
    tick(4'b0101, 1'b0);
    check("own2_gnt", 32'(Gnt), 32'h4);
    tick(4'b0001, 1'b0);
    check("handover_gnt", 32'(Gnt), 32'h1);
    check("handover_sel", 32'(Sel), 32'h0);
    check("handover_valid", 32'(Valid), 32'h1);
    tick(4'b0000, 1'b0);
    check("drop_valid", 32'(Valid), 32'h0);
    check("drop_sel_hold", 32'(Sel), 32'h0);
    tick(4'b1010, 1'b0);
    check("ptr1_gnt", 32'(Gnt), 32'h2);

    // Reset in the middle of owner 3's burst
    tick(4'b1000, 1'b0);
    check("own3_gnt", 32'(Gnt), 32'h8);
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b1);
    check("rst_gnt", 32'(Gnt), 32'h0);
    check("rst_sel", 32'(Sel), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_f", 32'(F), 32'(A));
    tick(4'b1000, 1'b0);
    check("post_rst_gnt", 32'(Gnt), 32'h8);

    // Random traffic: requests mostly held, occasional resets, fresh data each cycle
    Req = 4'b0;
    for (int j = 0; j < 3000; j++) begin
      logic [3:0] rq;
      logic       rr;
      rq = Req;
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      rr = ($urandom_range(0, 99) == 0);
      A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
      tick(rq, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
